// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg -- shared types for the MEM->WB pipeline register.
//
// The payload struct is sized for the largest supported configuration
// (4 lanes, 8-bit GPR address, 64-bit data). A wb_pipe_reg instance fills the
// low bits it uses and keeps the rest at zero, so one struct type serves every
// parameterisation of the top.
//
// Contents:
//   WB_MAX_*      upper bounds on LANES / ADDR_W / DATA_W
//   NOP_REG_ADDR  GPR address whose writes are discarded ($zero)
//   wb_payload_t  lane arrays + HI/LO + LLbit fields
//   WB_BUBBLE     all-zero payload loaded when the stage holds nothing
//   wb_resolve    applies $zero masking and same-address lane arbitration
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_MAX_LANES  = 4;
    localparam int WB_MAX_ADDR_W = 8;
    localparam int WB_MAX_DATA_W = 64;

    localparam logic [WB_MAX_ADDR_W-1:0] NOP_REG_ADDR = '0;

    typedef struct packed {
        logic [WB_MAX_LANES-1:0]                    wen;
        logic [WB_MAX_LANES-1:0][WB_MAX_ADDR_W-1:0] waddr;
        logic [WB_MAX_LANES-1:0][WB_MAX_DATA_W-1:0] wdata;
        logic                                       hilo_wen;
        logic [WB_MAX_DATA_W-1:0]                   hi;
        logic [WB_MAX_DATA_W-1:0]                   lo;
        logic                                       llbit_wen;
        logic                                       llbit;
    } wb_payload_t;

    localparam wb_payload_t WB_BUBBLE = '0;

    // Lanes writing $zero are dropped and their data cleared. Among enabled
    // lanes hitting the same register the highest-numbered lane wins; a lower
    // lane already cleared by a higher one can never un-clear another lane, so
    // a single in-order sweep is sufficient.
    function automatic wb_payload_t wb_resolve(input wb_payload_t raw);
        wb_payload_t p;
        p = raw;
        for (int i = 0; i < WB_MAX_LANES; i++) begin
            if (p.waddr[i] == NOP_REG_ADDR) begin
                p.wen[i]   = 1'b0;
                p.wdata[i] = '0;
            end
        end
        for (int j = 1; j < WB_MAX_LANES; j++) begin
            for (int i = 0; i < j; i++) begin
                if (p.wen[i] && p.wen[j] && (p.waddr[i] == p.waddr[j]))
                    p.wen[i] = 1'b0;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// -----------------------------------------------------------------------------
// wb_skid_buf -- one-entry holding slot for a payload accepted while the
// output register is stalled.
//
// Ports:
//   clk, rst   clock / synchronous active-high reset
//   flush      empties the slot (reset has priority, then flush, then push)
//   push       capture din (only issued while the output is stalled)
//   pop        slot content has been moved to the output register
//   din        resolved payload from upstream
//   valid      slot holds a payload
//   dout       held payload
// -----------------------------------------------------------------------------
module wb_skid_buf
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  wb_payload_t din,
    output logic        valid,
    output wb_payload_t dout
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= 1'b0;
            dout  <= WB_BUBBLE;
        end else if (push) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_pipe_reg.sv
// -----------------------------------------------------------------------------
// wb_pipe_reg -- MEM->WB pipeline register with valid/ready handshake.
//
// Captures a multi-lane GPR write-back payload plus HI/LO and LLbit writes,
// applying $zero masking and same-address lane arbitration on capture so the
// WB stage sees clean, registered enables. Empty cycles load an all-zero
// bubble and are counted in a saturating 32-bit counter.
//
// Build option: define WB_PIPE_SKID_EN to add a one-entry skid buffer, which
// makes in_ready a registered signal (no path from out_ready). Without it,
// in_ready = out_ready || !out_valid.
//
// Parameters: LANES (1..4), DATA_W (<=64), ADDR_W (<=8)
//
// Ports:
//   clk, rst                        clock / synchronous active-high reset
//   in_valid, in_ready              upstream handshake
//   in_wen/in_waddr/in_wdata        per-lane GPR write, lane i in slice i
//   in_hilo_wen, in_hi, in_lo       HI/LO write
//   in_llbit_wen, in_llbit          LLbit write
//   flush                           drop held and incoming payloads
//   out_valid, out_ready            downstream handshake
//   out_*                           registered, resolved payload
//   bubble_cnt                      cycles with out_valid low (saturating)
// -----------------------------------------------------------------------------
module wb_pipe_reg
    import wb_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_wen,
    input  logic [LANES*ADDR_W-1:0]  in_waddr,
    input  logic [LANES*DATA_W-1:0]  in_wdata,
    input  logic                     in_hilo_wen,
    input  logic [DATA_W-1:0]        in_hi,
    input  logic [DATA_W-1:0]        in_lo,
    input  logic                     in_llbit_wen,
    input  logic                     in_llbit,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_wen,
    output logic [LANES*ADDR_W-1:0]  out_waddr,
    output logic [LANES*DATA_W-1:0]  out_wdata,
    output logic                     out_hilo_wen,
    output logic [DATA_W-1:0]        out_hi,
    output logic [DATA_W-1:0]        out_lo,
    output logic                     out_llbit_wen,
    output logic                     out_llbit,
    output logic [31:0]              bubble_cnt
);

    wb_payload_t in_raw;
    wb_payload_t in_res;
    wb_payload_t out_reg;
    wb_payload_t load_data;
    logic        out_valid_reg;
    logic        load_valid;
    logic        accept;
    logic        advance;
    logic [31:0] bubble_count;
    logic        unused_upper;

    always_comb begin
        in_raw = WB_BUBBLE;
        for (int i = 0; i < LANES; i++) begin
            in_raw.wen[i]               = in_wen[i];
            in_raw.waddr[i][ADDR_W-1:0] = in_waddr[i*ADDR_W +: ADDR_W];
            in_raw.wdata[i][DATA_W-1:0] = in_wdata[i*DATA_W +: DATA_W];
        end
        in_raw.hilo_wen          = in_hilo_wen;
        in_raw.hi[DATA_W-1:0]    = in_hi;
        in_raw.lo[DATA_W-1:0]    = in_lo;
        in_raw.llbit_wen         = in_llbit_wen;
        in_raw.llbit             = in_llbit;
    end

    assign in_res  = wb_resolve(in_raw);
    assign accept  = in_valid && in_ready;
    // The output register may take new content whenever it is empty or the
    // downstream stage is consuming what it holds.
    assign advance = out_ready || !out_valid_reg;

`ifdef WB_PIPE_SKID_EN
    logic        skid_valid;
    logic        skid_push;
    logic        skid_pop;
    wb_payload_t skid_data;

    assign in_ready   = !skid_valid;
    assign skid_push  = accept && !advance;
    assign skid_pop   = advance && skid_valid;
    // Skid content is older than anything upstream, so it drains first.
    assign load_valid = skid_valid || accept;
    assign load_data  = skid_valid ? skid_data : in_res;

    wb_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (skid_push),
        .pop   (skid_pop),
        .din   (in_res),
        .valid (skid_valid),
        .dout  (skid_data)
    );
`else
    assign in_ready   = out_ready || !out_valid_reg;
    assign load_valid = accept;
    assign load_data  = in_res;
`endif

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid_reg <= 1'b0;
            out_reg       <= WB_BUBBLE;
        end else if (advance) begin
            out_valid_reg <= load_valid;
            out_reg       <= load_valid ? load_data : WB_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bubble_count <= '0;
        else if (!out_valid_reg && (bubble_count != 32'hFFFF_FFFF))
            bubble_count <= bubble_count + 32'd1;
    end

    always_comb begin
        out_wen   = '0;
        out_waddr = '0;
        out_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            out_wen[i]                     = out_reg.wen[i];
            out_waddr[i*ADDR_W +: ADDR_W]  = out_reg.waddr[i][ADDR_W-1:0];
            out_wdata[i*DATA_W +: DATA_W]  = out_reg.wdata[i][DATA_W-1:0];
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_hilo_wen  = out_reg.hilo_wen;
    assign out_hi        = out_reg.hi[DATA_W-1:0];
    assign out_lo        = out_reg.lo[DATA_W-1:0];
    assign out_llbit_wen = out_reg.llbit_wen;
    assign out_llbit     = out_reg.llbit;
    assign bubble_cnt    = bubble_count;

    // Lanes and bits beyond this instance's parameters are held at zero.
    assign unused_upper  = ^out_reg;

endmodule
